// File: rtl/object_memory_controller.sv
// Object memory owner: grants the new-game handshake, checks the board load stream
// for order and completeness, then serves game-logic writes and two synchronous reads.
module object_memory_controller #(
    parameter int BOARD_CELLS   = 106,
    parameter int GRANT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        new_game_request,
    output logic        new_game_in_progress,
    input  logic        resetting,
    input  logic        new_game_ready,
    input  logic [6:0]  address_write_om,
    input  logic [10:0] data_write_om,
    input  logic        wren,
    input  logic [6:0]  game_address,
    input  logic [10:0] game_data_write,
    input  logic        game_wren,
    output logic [10:0] game_data_read,
    input  logic [6:0]  display_address,
    output logic [10:0] display_data,
    output logic        board_valid,
    output logic        load_error
);
    localparam int CNT_W = $clog2(GRANT_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, GRANT, LOADING, RUNNING} state_t;

    state_t            state, state_d;
    logic [7:0]        next_expected, next_expected_d;
    logic [CNT_W-1:0]  grant_count, grant_count_d;
    logic              grant_d, error_d, drain, drain_d, resetting_q;
    logic              load_window, order_ok, order_repeat, load_complete;
    logic              mem_we;
    logic [6:0]        mem_addr;
    logic [10:0]       mem_wdata;
    logic [10:0]       mem [128];

    assign board_valid = (state == RUNNING);

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d         = state;
        next_expected_d = next_expected;
        grant_count_d   = grant_count;
        grant_d         = 1'b0;
        error_d         = load_error;
        drain_d         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = address_write_om;
        mem_wdata       = data_write_om;

        load_window   = (state == LOADING) || drain;
        order_ok      = ({1'b0, address_write_om} == next_expected);
        order_repeat  = ({1'b0, address_write_om} == next_expected - 8'd1);
        load_complete = new_game_ready || (resetting_q && !resetting);

        // The load stream owns the write port through the drain cycle.
        if (load_window && wren) begin
            mem_we = 1'b1;
            if (order_ok) begin
                if (next_expected != 8'hFF)
                    next_expected_d = next_expected + 8'd1;
            end else if (!order_repeat) begin
                error_d = 1'b1;
            end
        end else if (state == RUNNING && !drain && game_wren) begin
            mem_we    = 1'b1;
            mem_addr  = game_address;
            mem_wdata = game_data_write;
        end

        case (state)
            IDLE, RUNNING: begin
                if (new_game_request) begin
                    state_d         = GRANT;
                    error_d         = 1'b0;
                    next_expected_d = '0;
                    grant_count_d   = '0;
                end
            end
            GRANT: begin
                if (resetting) begin
                    state_d = LOADING;
                end else if (grant_count == CNT_W'(GRANT_TIMEOUT - 1)) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                end else begin
                    grant_count_d = grant_count + 1'b1;
                    grant_d       = 1'b1;
                end
            end
            LOADING: begin
                // Completeness counts a write landing on the completion cycle itself.
                if (load_complete) begin
                    state_d = RUNNING;
                    drain_d = 1'b1;
                    if (next_expected_d != 8'(BOARD_CELLS))
                        error_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            next_expected        <= '0;
            grant_count          <= '0;
            new_game_in_progress <= 1'b0;
            load_error           <= 1'b0;
            drain                <= 1'b0;
            resetting_q          <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state                <= state_d;
            next_expected        <= next_expected_d;
            grant_count          <= grant_count_d;
            new_game_in_progress <= grant_d;
            load_error           <= error_d;
            drain                <= drain_d;
            resetting_q          <= resetting;
        end
    end

    // NOTE: the array has no reset so it maps onto block RAM; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            game_data_read <= '0;
            display_data   <= '0;
        end else begin
            game_data_read <= mem[game_address];
            display_data   <= mem[display_address];
        end
    end
endmodule

// File: tb/tb_object_memory_controller.sv
// Directed handshake sequence with randomized data, checked against an array model
// of the object memory and the expected handshake outputs.
module tb_object_memory_controller;
    logic        clk = 1'b0;
    logic        reset;
    logic        new_game_request, new_game_in_progress, resetting, new_game_ready;
    logic [6:0]  address_write_om, game_address, display_address;
    logic [10:0] data_write_om, game_data_write, game_data_read, display_data;
    logic        wren, game_wren, board_valid, load_error;

    int          checks = 0;
    int          failures = 0;
    logic [10:0] model_mem [128];
    bit          written [128];

    object_memory_controller dut (
        .clk                  (clk),
        .reset                (reset),
        .new_game_request     (new_game_request),
        .new_game_in_progress (new_game_in_progress),
        .resetting            (resetting),
        .new_game_ready       (new_game_ready),
        .address_write_om     (address_write_om),
        .data_write_om        (data_write_om),
        .wren                 (wren),
        .game_address         (game_address),
        .game_data_write      (game_data_write),
        .game_wren            (game_wren),
        .game_data_read       (game_data_read),
        .display_address      (display_address),
        .display_data         (display_data),
        .board_valid          (board_valid),
        .load_error           (load_error)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_hs(input string tag, input logic g, input logic v, input logic e);
        check({tag, ".grant"}, 32'(new_game_in_progress), 32'(g));
        check({tag, ".valid"}, 32'(board_valid), 32'(v));
        check({tag, ".error"}, 32'(load_error), 32'(e));
    endtask

    // One load-port write; the model stores it because the write lands in the load window.
    task automatic load_write(input logic [6:0] a, input logic [10:0] d);
        wren = 1'b1;
        address_write_om = a;
        data_write_om = d;
        model_mem[a] = d;
        written[a] = 1'b1;
        tick();
        wren = 1'b0;
    endtask

    // Request pulse, one cycle to see the grant, then resetting rises.
    task automatic start_load();
        new_game_request = 1'b1;
        tick();
        new_game_request = 1'b0;
        tick();
        resetting = 1'b1;
        tick();
    endtask

    initial begin
        logic [6:0]  ra;
        logic [10:0] rd;
        logic [10:0] old;
        bit          had_old;

        reset = 1'b1;
        {new_game_request, resetting, new_game_ready, wren, game_wren} = '0;
        address_write_om = '0; data_write_om = '0;
        game_address = '0; game_data_write = '0; display_address = '0;
        #1;
        check_hs("reset", 1'b0, 1'b0, 1'b0);
        check("reset.game_rd", 32'(game_data_read), 32'h0);
        check("reset.disp_rd", 32'(display_data), 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Nominal load: grant latency, then 106 ordered writes of addr+3.
        new_game_request = 1'b1;
        tick();
        new_game_request = 1'b0;
        check_hs("req.edgeN", 1'b0, 1'b0, 1'b0);
        tick();
        check_hs("req.edgeN1", 1'b1, 1'b0, 1'b0);
        resetting = 1'b1;
        tick();
        check_hs("loading.entry", 1'b0, 1'b0, 1'b0);
        for (int a = 0; a < 106; a++) begin
            if (a > 0) display_address = 7'(a - 1);
            load_write(7'(a), 11'(a + 3));
            if (a > 0) check("nominal.partial_read", 32'(display_data), 32'(a + 2));
        end
        game_wren = 1'b1; game_address = 7'd10; game_data_write = 11'h7FF;
        tick();
        game_wren = 1'b0;
        resetting = 1'b0;
        new_game_ready = 1'b1;
        tick();
        new_game_ready = 1'b0;
        check_hs("nominal.done", 1'b0, 1'b1, 1'b0);
        game_wren = 1'b1; game_address = 7'd11; game_data_write = 11'h123;
        load_write(7'd105, 11'd108);
        game_wren = 1'b0;
        check_hs("nominal.drain", 1'b0, 1'b1, 1'b0);
        display_address = 7'd57; game_address = 7'd11;
        tick();
        check("nominal.disp57", 32'(display_data), 32'd60);
        check("drain.game_ignored", 32'(game_data_read), 32'(model_mem[11]));
        game_address = 7'd10;
        tick();
        check("loading.game_ignored", 32'(game_data_read), 32'(model_mem[10]));

        // Game access: same-edge read returns old data, next read the new value.
        game_wren = 1'b1; game_address = 7'd10; game_data_write = 11'h7FF;
        tick();
        game_wren = 1'b0;
        check("game.rdw_old", 32'(game_data_read), 32'(model_mem[10]));
        model_mem[10] = 11'h7FF;
        tick();
        check("game.rd_new", 32'(game_data_read), 32'h7FF);
        wren = 1'b1; address_write_om = 7'd20; data_write_om = 11'h000;
        tick();
        wren = 1'b0; display_address = 7'd20;
        tick();
        check("running.wren_ignored", 32'(display_data), 32'(model_mem[20]));

        for (int i = 0; i < 16; i++) begin
            ra = 7'($urandom_range(0, 127));
            rd = 11'($urandom_range(0, 2047));
            had_old = written[ra];
            old = model_mem[ra];
            game_wren = 1'b1; game_address = ra; game_data_write = rd; display_address = ra;
            tick();
            game_wren = 1'b0;
            if (had_old) check("rand.disp_old", 32'(display_data), 32'(old));
            model_mem[ra] = rd;
            written[ra] = 1'b1;
            tick();
            check("rand.game_new", 32'(game_data_read), 32'(rd));
            check("rand.disp_new", 32'(display_data), 32'(rd));
        end

        // Short load: 100 cells then ready flags the board incomplete.
        start_load();
        for (int a = 0; a < 100; a++) load_write(7'(a), 11'($urandom_range(0, 2047)));
        resetting = 1'b0;
        new_game_ready = 1'b1;
        tick();
        new_game_ready = 1'b0;
        check_hs("short.done", 1'b0, 1'b1, 1'b1);
        tick();

        // Out-of-order load; a repeat of the last address is tolerated, a skip is not.
        new_game_request = 1'b1;
        tick();
        new_game_request = 1'b0;
        check_hs("regrant.clear", 1'b0, 1'b0, 1'b0);
        tick();
        resetting = 1'b1;
        tick();
        load_write(7'd0, 11'($urandom_range(0, 2047)));
        load_write(7'd1, 11'($urandom_range(0, 2047)));
        load_write(7'd1, 11'($urandom_range(0, 2047)));
        check_hs("ooo.repeat_ok", 1'b0, 1'b0, 1'b0);
        load_write(7'd5, 11'($urandom_range(0, 2047)));
        check_hs("ooo.skip", 1'b0, 1'b0, 1'b1);
        resetting = 1'b0;
        tick();
        check_hs("ooo.fall_done", 1'b0, 1'b1, 1'b1);
        tick();

        // Grant timeout: 16 cycles in GRANT without resetting.
        new_game_request = 1'b1;
        tick();
        new_game_request = 1'b0;
        check_hs("timeout.entry", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        check_hs("timeout.cycle15", 1'b1, 1'b0, 1'b0);
        tick();
        check_hs("timeout.expired", 1'b0, 1'b0, 1'b1);

        // Async reset while granted drops the grant without a clock edge.
        new_game_request = 1'b1;
        tick();
        new_game_request = 1'b0;
        tick();
        check("rst_grant.pre", 32'(new_game_in_progress), 32'h1);
        reset = 1'b1;
        #1;
        check_hs("rst_grant.async", 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // Async reset mid-load after write 40; memory must keep cells 0..40.
        start_load();
        display_address = 7'd3; game_address = 7'd3;
        for (int a = 0; a <= 40; a++) load_write(7'(a), 11'($urandom_range(1, 2047)));
        check("rst_load.pre_read", 32'(display_data), 32'(model_mem[3]));
        reset = 1'b1;
        #1;
        check_hs("rst_load.async", 1'b0, 1'b0, 1'b0);
        check("rst_load.game_rd", 32'(game_data_read), 32'h0);
        check("rst_load.disp_rd", 32'(display_data), 32'h0);
        tick();
        reset = 1'b0;
        new_game_ready = 1'b1;
        wren = 1'b1; address_write_om = 7'd41; data_write_om = ~model_mem[41];
        tick();
        new_game_ready = 1'b0; wren = 1'b0; resetting = 1'b0;
        tick();
        check_hs("rst_load.idle", 1'b0, 1'b0, 1'b0);
        for (int a = 0; a <= 41; a++) begin
            display_address = 7'(a);
            game_address = 7'(41 - a);
            tick();
            check("rst_load.disp_keep", 32'(display_data), 32'(model_mem[a]));
            check("rst_load.game_keep", 32'(game_data_read), 32'(model_mem[41 - a]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/object_memory_controller.md
# object_memory_controller

Responder side of the new-game handshake and owner of the 128 x 11-bit object memory. Grants the coordinator's new-game request, accepts the board load stream, checks it for ordering and completeness, then hands the memory to game logic for writes and serves two synchronous read ports (game logic, display). Sits between new_game_coordinator, the game-logic core and the display scanner.

## Interface
- BOARD_CELLS, 106: number of cells a complete board load writes, addresses 0..BOARD_CELLS-1.
- GRANT_TIMEOUT, 16: cycles to wait in GRANT for resetting before abandoning the grant.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high; one clock, asynchronous active-high reset.
- new_game_request  in  1  one-cycle request pulse from the coordinator.
- new_game_in_progress  out  1  grant; held high until resetting is seen.
- resetting  in  1  coordinator load-in-progress level.
- new_game_ready  in  1  one-cycle load-complete pulse.
- address_write_om  in  7  load write address.
- data_write_om  in  11  load write data.
- wren  in  1  load write enable.
- game_address  in  7  game-logic read/write address.
- game_data_write  in  11  game-logic write data.
- game_wren  in  1  game-logic write enable.
- game_data_read  out  11  game-logic read data, 1-cycle latency.
- display_address  in  7  display read address.
- display_data  out  11  display read data, 1-cycle latency.
- board_valid  out  1  high only in RUNNING.
- load_error  out  1  sticky; set on bad load or grant timeout, cleared on next grant.

## Operation
- States: IDLE, GRANT, LOADING, RUNNING.
- IDLE: board_valid=0. new_game_request -> GRANT.
- GRANT: new_game_in_progress=1, load_error cleared on entry, next_expected=0, timeout counter=0. resetting=1 -> LOADING, new_game_in_progress drops. Counter reaching GRANT_TIMEOUT -> IDLE, load_error=1.
- LOADING: each cycle with wren=1 writes data_write_om to address_write_om. Ordering check: address==next_expected -> write, next_expected+1; address==next_expected-1 (repeat of last) -> write, no count; any other -> write, load_error=1. Completion on new_game_ready=1 or resetting falling (same cycle counts once) -> RUNNING; load_error=1 if next_expected != BOARD_CELLS.
- Drain cycle: first RUNNING cycle still accepts one load write (wren=1) under the same ordering rule; game_wren ignored that cycle.
- RUNNING: board_valid=1; game_wren=1 writes game_data_write to game_address; wren ignored. new_game_request -> GRANT, board_valid drops.
- new_game_request ignored in GRANT and LOADING. game_wren ignored outside RUNNING (after drain).
- Read ports always active in every state; display reads during LOADING return partially loaded contents.
- next_expected is 8 bits, saturates at 255; no wrap.

## Timing
- Reset values: state IDLE, new_game_in_progress=0, board_valid=0, load_error=0, game_data_read=0, display_data=0, counters 0. Memory contents not cleared by reset.
- Request pulse at edge N -> new_game_in_progress=1 after edge N+1.
- resetting sampled high at edge M -> new_game_in_progress=0 and state LOADING after edge M.
- Write presented at edge K is visible on either read port for a read address presented at edge K+1 or later.
- Read-during-write same address, same edge: read returns old data.
- Completion pulse at edge C -> board_valid=1 after edge C.
- Reset asserted mid-GRANT/LOADING: immediate return to IDLE, grant dropped; a later resetting/new_game_ready is ignored.

## Test plan
- Nominal load: request pulse, resetting 2 cycles later, 106 writes addr 0..105 data=addr+3, ready pulse with final repeat write of 105 in drain cycle -> board_valid=1, load_error=0, display read of 57 returns 60.
- Short load: writes 0..99 then ready -> RUNNING, load_error=1, board_valid=1.
- Out-of-order: write 0,1,5 during LOADING -> load_error=1 after the write of 5.
- Grant timeout: request, resetting never rises -> after 16 cycles in GRANT state IDLE, new_game_in_progress=0, load_error=1.
- Game access: in RUNNING, game_wren write 0x7FF to 10 with a same-edge read of 10 -> old value, next-cycle read -> 0x7FF; game_wren during LOADING -> no effect.
- Async reset mid-LOADING at write 40 -> outputs zero immediately, state IDLE; previously written cells 0..40 still read back.
